// File: rtl/lemming_pkg.sv
// Shared lemming types: walk direction encoding and the decoder used by
// every stage that consumes the walk FSM's state outputs.
package lemming_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } dir_t;

    // Exactly one of the two walk flags must be set to give a direction;
    // both set or neither set means the lemming does not move.
    function automatic dir_t decode_dir(input logic walk_left, input logic walk_right);
        dir_t d;
        d = DIR_NONE;
        if (walk_left && !walk_right) begin
            d = DIR_L;
        end else if (walk_right && !walk_left) begin
            d = DIR_R;
        end
        return d;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Enable-gated modulo-DIV counter. tick is high combinationally during the
// last enabled cycle of each period, so the first tick lands on the DIV-th
// enabled cycle after reset. Reused by the fall and dig timers.
module step_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic areset_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("step_prescaler: DIV must be >= 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count only while enabled; hold otherwise, wrap to zero on the tick cycle.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/lemming_track.sv
// World model for the lemming walk FSM: moves the lemming along a bounded
// track on prescaled ticks and raises one-cycle bump pulses at the ends,
// which feed back into the walk FSM. Also counts wall hits (saturating).
module lemming_track
    import lemming_pkg::*;
#(
    parameter int TRACK_LEN = 16,
    parameter int STEP_DIV  = 4,
    parameter int START_POS = 0
) (
    input  logic                         clk,
    input  logic                         areset_n,
    input  logic                         en,
    input  logic                         walk_left,
    input  logic                         walk_right,
    output logic [$clog2(TRACK_LEN)-1:0] pos,
    output logic                         bump_left,
    output logic                         bump_right,
    output logic                         step,
    output logic [7:0]                   wall_hits
);

    localparam int PW = $clog2(TRACK_LEN);
    localparam logic [PW-1:0] POS_MAX   = PW'(TRACK_LEN - 1);
    localparam logic [PW-1:0] POS_START = PW'(START_POS);

    generate
        if (STEP_DIV < 2) begin : g_bad_step_div
            $error("lemming_track: STEP_DIV must be >= 2 so each wall hit bumps once");
        end
        if (TRACK_LEN < 2) begin : g_bad_len
            $error("lemming_track: TRACK_LEN must be >= 2");
        end
        if (START_POS >= TRACK_LEN) begin : g_bad_start
            $error("lemming_track: START_POS must be < TRACK_LEN");
        end
    endgenerate

    logic tick;
    dir_t dir;
    logic hit_left;
    logic hit_right;

    step_prescaler #(
        .DIV(STEP_DIV)
    ) u_prescaler (
        .clk      (clk),
        .areset_n (areset_n),
        .en       (en),
        .tick     (tick)
    );

    assign dir       = decode_dir(walk_left, walk_right);
    assign hit_left  = tick && (dir == DIR_L) && (pos == '0);
    assign hit_right = tick && (dir == DIR_R) && (pos == POS_MAX);

    // Position and one-cycle pulses; a tick either moves the lemming or
    // bumps a wall, never both, and pulses clear on every other edge.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pos        <= POS_START;
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            step       <= 1'b0;
        end else begin
            bump_left  <= hit_left;
            bump_right <= hit_right;
            step       <= 1'b0;
            if (tick) begin
                case (dir)
                    DIR_L: begin
                        if (pos != '0) begin
                            pos  <= pos - PW'(1);
                            step <= 1'b1;
                        end
                    end
                    DIR_R: begin
                        if (pos != POS_MAX) begin
                            pos  <= pos + PW'(1);
                            step <= 1'b1;
                        end
                    end
                    default: begin
                        pos <= pos;
                    end
                endcase
            end
        end
    end

    // Wall hit counter advances on the same edge as the bump and sticks at 255.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wall_hits <= 8'h00;
        end else if ((hit_left || hit_right) && (wall_hits != 8'hFF)) begin
            wall_hits <= wall_hits + 8'h01;
        end
    end

endmodule
